out_src_sequencer: RTL and testbench

Sequences glitch-free switching of the HDMI transmitter's output source between the internal test-pattern generator and the scanconverter output. Runs in the clk27 domain between the CPU system-control PIO and the top-level output mux. It waits for a frame boundary on the current source, then blanks the output. It optionally resets the HDMI transmitter, flips the mux select, and holds blank until the sink settles. Status outputs return to the CPU through the controls PIO.

---
 rtl/out_src_seq_pkg.sv | 34 +++
 rtl/sync_fall_edge.sv | 30 +++
 rtl/out_src_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_out_src_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_src_seq_pkg.sv
// Shared types and constants for the HDMI output-source sequencer.
// Holds the FSM state encoding, mux-select encodings, default cycle counts
// and a helper that sizes the shared cycle counter.
package out_src_seq_pkg;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_WAIT_VS = 3'd2,
        ST_BLANK   = 3'd3,
        ST_TXRST   = 3'd4,
        ST_SETTLE  = 3'd5
    } seq_state_e;

    localparam logic SEL_VIDEOGEN = 1'b1;
    localparam logic SEL_SCANCONV = 1'b0;

    // 10 us, 1 ms and 50 ms at 27 MHz
    localparam int DEF_RST_CYCLES     = 270;
    localparam int DEF_SETTLE_CYCLES  = 27000;
    localparam int DEF_TIMEOUT_CYCLES = 1350000;

    // Width of a counter able to reach (largest count - 1); never narrower than 1 bit
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        int w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_fall_edge.sv
// Brings an asynchronous active-low strobe into the clk27 domain through a
// two-flop synchroniser and flags its falling edge with a one-cycle pulse.
// Flops reset high so an idle (high) input never produces a spurious edge.
module sync_fall_edge (
    input  logic clk27,
    input  logic reset_n,
    input  logic async_i,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Two-stage synchroniser followed by a previous-value register for edge detection
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign fall_o = prev_q & ~sync2_q;

endmodule

// File: rtl/out_src_sequencer.sv
// Glitch-free output source switch between the test-pattern generator and the
// scanconverter. Waits for a VSYNC falling edge (or a timeout), blanks the
// output, optionally pulses the HDMI transmitter reset, flips the mux select
// and holds blank until the sink has settled.
// Optional feature macro: OUTSEQ_TXRST_EN enables the transmitter-reset phase;
// without it tx_rst_n is tied high and the TXRST phase is skipped.
module out_src_sequencer
    import out_src_seq_pkg::*;
#(
    parameter int RST_CYCLES     = DEF_RST_CYCLES,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk27,
    input  logic       reset_n,
    input  logic       sel_req,
    input  logic       vsync_cur,
    output logic       sel_out,
    output logic       blank,
    output logic       tx_rst_n,
    output logic       busy,
    output logic       timeout,
    output logic [7:0] sw_count
);

    localparam int CW = cnt_width(RST_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES);

    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
`ifdef OUTSEQ_TXRST_EN
    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
`endif

    seq_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          target_q;
    logic          from_init_q;
    logic          sel_out_q;
    logic          blank_q;
    logic          busy_q;
    logic          timeout_q;
    logic [7:0]    sw_count_q;
    logic          vs_fall;

    sync_fall_edge u_vs_sync (
        .clk27   (clk27),
        .reset_n (reset_n),
        .async_i (vsync_cur),
        .fall_o  (vs_fall)
    );

`ifdef OUTSEQ_TXRST_EN
    logic tx_rst_n_q;

    // Sequencer FSM with registered outputs, including the transmitter reset
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            target_q    <= SEL_VIDEOGEN;
            from_init_q <= 1'b1;
            sel_out_q   <= SEL_VIDEOGEN;
            blank_q     <= 1'b1;
            busy_q      <= 1'b1;
            timeout_q   <= 1'b0;
            sw_count_q  <= 8'd0;
            tx_rst_n_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    if (cnt_q == RST_LAST) begin
                        state_q    <= ST_SETTLE;
                        cnt_q      <= '0;
                        tx_rst_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (sel_req != sel_out_q) begin
                        state_q  <= ST_WAIT_VS;
                        target_q <= sel_req;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                ST_WAIT_VS: begin
                    if (sel_req == sel_out_q) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (vs_fall) begin
                        state_q <= ST_BLANK;
                        blank_q <= 1'b1;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_q   <= ST_BLANK;
                        blank_q   <= 1'b1;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_BLANK: begin
                    state_q    <= ST_TXRST;
                    sel_out_q  <= target_q;
                    cnt_q      <= '0;
                    tx_rst_n_q <= 1'b0;
                end
                ST_TXRST: begin
                    if (cnt_q == RST_LAST) begin
                        state_q    <= ST_SETTLE;
                        cnt_q      <= '0;
                        tx_rst_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_q     <= ST_IDLE;
                        blank_q     <= 1'b0;
                        busy_q      <= 1'b0;
                        from_init_q <= 1'b0;
                        if (!from_init_q) begin
                            sw_count_q <= sw_count_q + 8'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign tx_rst_n = tx_rst_n_q;
`else
    // Sequencer FSM with registered outputs; the transmitter is never reset
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            target_q    <= SEL_VIDEOGEN;
            from_init_q <= 1'b1;
            sel_out_q   <= SEL_VIDEOGEN;
            blank_q     <= 1'b1;
            busy_q      <= 1'b1;
            timeout_q   <= 1'b0;
            sw_count_q  <= 8'd0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                ST_INIT, ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_q     <= ST_IDLE;
                        blank_q     <= 1'b0;
                        busy_q      <= 1'b0;
                        from_init_q <= 1'b0;
                        if (!from_init_q) begin
                            sw_count_q <= sw_count_q + 8'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (sel_req != sel_out_q) begin
                        state_q  <= ST_WAIT_VS;
                        target_q <= sel_req;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                ST_WAIT_VS: begin
                    if (sel_req == sel_out_q) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (vs_fall) begin
                        state_q <= ST_BLANK;
                        blank_q <= 1'b1;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_q   <= ST_BLANK;
                        blank_q   <= 1'b1;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_BLANK: begin
                    state_q   <= ST_SETTLE;
                    sel_out_q <= target_q;
                    cnt_q     <= '0;
                end
                default: begin
                    state_q <= ST_INIT;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign tx_rst_n = 1'b1;
`endif

    assign sel_out  = sel_out_q;
    assign blank    = blank_q;
    assign busy     = busy_q;
    assign timeout  = timeout_q;
    assign sw_count = sw_count_q;

endmodule

// File: tb/tb_out_src_sequencer.sv
// Directed testbench for out_src_sequencer with RST=4, SETTLE=16, TIMEOUT=100.
// Inputs change on the falling clock edge and outputs are sampled there too.
// Builds with or without OUTSEQ_TXRST_EN; expected timings adapt accordingly.
module tb_out_src_sequencer;

    localparam int RST     = 4;
    localparam int SETTLE  = 16;
    localparam int TIMEOUT = 100;
`ifdef OUTSEQ_TXRST_EN
    localparam int   RSTE       = RST;
    localparam logic TX_RST_VAL = 1'b0;
`else
    localparam int   RSTE       = 0;
    localparam logic TX_RST_VAL = 1'b1;
`endif
    localparam int BLANK_LEN = 1 + RSTE + SETTLE;

    logic       clk27;
    logic       reset_n;
    logic       sel_req;
    logic       vsync_cur;
    logic       sel_out;
    logic       blank;
    logic       tx_rst_n;
    logic       busy;
    logic       timeout;
    logic [7:0] sw_count;

    int vectors;
    int miscompares;

    out_src_sequencer #(
        .RST_CYCLES     (RST),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk27     (clk27),
        .reset_n   (reset_n),
        .sel_req   (sel_req),
        .vsync_cur (vsync_cur),
        .sel_out   (sel_out),
        .blank     (blank),
        .tx_rst_n  (tx_rst_n),
        .busy      (busy),
        .timeout   (timeout),
        .sw_count  (sw_count)
    );

    // 27 MHz-like free-running clock (period is nominal in simulation)
    initial begin
        clk27 = 1'b0;
        forever #5 clk27 = ~clk27;
    end

    // Releases reset on a falling edge and times the INIT sequence that follows
    task automatic test_init_sequence(input string name);
        int firstTxHigh;
        int firstBlankLow;
        firstTxHigh   = -1;
        firstBlankLow = -1;
        @(negedge clk27);
        reset_n = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            if (firstTxHigh < 0 && tx_rst_n === 1'b1) firstTxHigh = k;
            if (firstBlankLow < 0 && blank === 1'b0) firstBlankLow = k;
            @(negedge clk27);
        end
        vectors++;
        if (firstTxHigh !== RSTE) begin
            miscompares++;
            $display("[TB] FAIL %s_tx_rst_low_cycles: got %0d, expected %0d", name, firstTxHigh, RSTE);
        end
        vectors++;
        if (firstBlankLow !== RSTE + SETTLE) begin
            miscompares++;
            $display("[TB] FAIL %s_blank_release_cycle: got %0d, expected %0d", name, firstBlankLow, RSTE + SETTLE);
        end
        vectors++;
        if (sel_out !== 1'b1 || busy !== 1'b0 || sw_count !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL %s_idle_outputs: got sel_out=%b busy=%b sw_count=%0d, expected 1 0 0",
                     name, sel_out, busy, sw_count);
        end
    endtask

    // Checks reset values while reset is held, then the INIT sequence on release
    task automatic test_reset();
        reset_n   = 1'b1;
        sel_req   = 1'b1;
        vsync_cur = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk27);
        vectors++;
        if (sel_out !== 1'b1 || blank !== 1'b1 || tx_rst_n !== TX_RST_VAL || busy !== 1'b1
            || timeout !== 1'b0 || sw_count !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_values: got sel=%b blank=%b tx=%b busy=%b to=%b cnt=%0d, expected 1 1 %b 1 0 0",
                     sel_out, blank, tx_rst_n, busy, timeout, sw_count, TX_RST_VAL);
        end
        test_init_sequence("reset");
    endtask

    // Switch 1->0 triggered by a VSYNC falling edge 10 cycles after the request
    task automatic test_switch_on_edge();
        int jBlank, jSel, blankHigh, txLow, toCount, jDone;
        jBlank = -1; jSel = -1; blankHigh = 0; txLow = 0; toCount = 0; jDone = -1;
        sel_req = 1'b0;
        @(negedge clk27);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL edge_busy_latency: got %b, expected 1", busy);
        end
        repeat (9) @(negedge clk27);
        vsync_cur = 1'b0;
        for (int j = 1; j <= 100; j++) begin
            @(negedge clk27);
            if (blank === 1'b1) blankHigh++;
            if (tx_rst_n === 1'b0) txLow++;
            if (timeout === 1'b1) toCount++;
            if (jBlank < 0 && blank === 1'b1) begin
                jBlank = j;
                vsync_cur = 1'b1;
            end
            if (jSel < 0 && sel_out === 1'b0) jSel = j;
            if (jBlank > 0 && blank === 1'b0) begin
                jDone = j;
                break;
            end
        end
        vectors++;
        if (jBlank < 2 || jBlank > 4) begin
            miscompares++;
            $display("[TB] FAIL edge_to_blank_latency: got %0d, expected 2..4", jBlank);
        end
        vectors++;
        if (jBlank < 0 || jSel !== jBlank + 1) begin
            miscompares++;
            $display("[TB] FAIL edge_sel_after_blank: got %0d, expected %0d", jSel, jBlank + 1);
        end
        vectors++;
        if (jDone < 0 || blankHigh !== BLANK_LEN) begin
            miscompares++;
            $display("[TB] FAIL edge_blank_length: got %0d, expected %0d", blankHigh, BLANK_LEN);
        end
        vectors++;
        if (txLow !== RSTE) begin
            miscompares++;
            $display("[TB] FAIL edge_tx_rst_length: got %0d, expected %0d", txLow, RSTE);
        end
        vectors++;
        if (toCount !== 0) begin
            miscompares++;
            $display("[TB] FAIL edge_no_timeout: got %0d pulses, expected 0", toCount);
        end
        vectors++;
        if (sel_out !== 1'b0 || busy !== 1'b0 || sw_count !== 8'd1) begin
            miscompares++;
            $display("[TB] FAIL edge_final: got sel=%b busy=%b cnt=%0d, expected 0 0 1", sel_out, busy, sw_count);
        end
    endtask

    // Switch 0->1 with VSYNC stuck high completes through the timeout path
    task automatic test_timeout();
        int toCount, jTo, jSel, jDone;
        toCount = 0; jTo = -1; jSel = -1; jDone = -1;
        sel_req = 1'b1;
        for (int j = 1; j <= 300; j++) begin
            @(negedge clk27);
            if (timeout === 1'b1) begin
                toCount++;
                if (jTo < 0) jTo = j;
            end
            if (jSel < 0 && sel_out === 1'b1) jSel = j;
            if (jSel > 0 && busy === 1'b0) begin
                jDone = j;
                break;
            end
        end
        vectors++;
        if (toCount !== 1) begin
            miscompares++;
            $display("[TB] FAIL timeout_pulse_count: got %0d, expected 1", toCount);
        end
        vectors++;
        if (jTo !== TIMEOUT + 1) begin
            miscompares++;
            $display("[TB] FAIL timeout_pulse_cycle: got %0d, expected %0d", jTo, TIMEOUT + 1);
        end
        vectors++;
        if (jSel !== TIMEOUT + 2) begin
            miscompares++;
            $display("[TB] FAIL timeout_sel_cycle: got %0d, expected %0d", jSel, TIMEOUT + 2);
        end
        vectors++;
        if (jDone < 0 || sel_out !== 1'b1 || sw_count !== 8'd2) begin
            miscompares++;
            $display("[TB] FAIL timeout_final: got done=%0d sel=%b cnt=%0d, expected done sel=1 cnt=2",
                     jDone, sel_out, sw_count);
        end
    endtask

    // Request withdrawn after 5 cycles in WAIT_VS: nothing may switch or blank
    task automatic test_abort();
        int blankSeen, selLost;
        blankSeen = 0; selLost = 0;
        sel_req = 1'b0;
        @(negedge clk27);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL abort_busy_start: got %b, expected 1", busy);
        end
        repeat (4) @(negedge clk27);
        sel_req = 1'b1;
        @(negedge clk27);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_back_to_idle: got busy=%b, expected 0", busy);
        end
        for (int j = 0; j < 20; j++) begin
            if (blank !== 1'b0) blankSeen++;
            if (sel_out !== 1'b1) selLost++;
            @(negedge clk27);
        end
        vectors++;
        if (blankSeen !== 0 || selLost !== 0) begin
            miscompares++;
            $display("[TB] FAIL abort_no_switch: got blank_cycles=%0d sel_changes=%0d, expected 0 0", blankSeen, selLost);
        end
        vectors++;
        if (sw_count !== 8'd2) begin
            miscompares++;
            $display("[TB] FAIL abort_sw_count: got %0d, expected 2", sw_count);
        end
    endtask

    // sel_req toggled during SETTLE: first switch finishes, second follows after one IDLE cycle
    task automatic test_back_to_back();
        int jSel, lowLen, firstGap, jDone;
        jSel = -1; lowLen = 0; firstGap = -1; jDone = -1;
        sel_req = 1'b0;
        for (int j = 1; j <= 400; j++) begin
            @(negedge clk27);
            if (j == 2) vsync_cur = 1'b0;
            if (j == 6) vsync_cur = 1'b1;
            if (jSel < 0 && sel_out === 1'b0) jSel = j;
            if (jSel > 0 && j == jSel + RSTE + 3) sel_req = 1'b1;
            if (busy === 1'b0) begin
                lowLen++;
            end else if (lowLen > 0) begin
                if (firstGap < 0) firstGap = lowLen;
                lowLen = 0;
            end
            if (sw_count === 8'd4 && busy === 1'b0) begin
                jDone = j;
                break;
            end
        end
        vectors++;
        if (jSel < 0) begin
            miscompares++;
            $display("[TB] FAIL b2b_first_switch: got no sel_out change, expected sel_out=0");
        end
        vectors++;
        if (firstGap !== 1) begin
            miscompares++;
            $display("[TB] FAIL b2b_idle_gap: got %0d cycles, expected 1", firstGap);
        end
        vectors++;
        if (jDone < 0 || sel_out !== 1'b1 || sw_count !== 8'd4) begin
            miscompares++;
            $display("[TB] FAIL b2b_final: got done=%0d sel=%b cnt=%0d, expected done sel=1 cnt=4",
                     jDone, sel_out, sw_count);
        end
    endtask

    // Reset asserted mid-switch must restore reset values at once, then INIT reruns
    task automatic test_reset_mid_txrst();
        int found;
        found = 0;
        sel_req = 1'b0;
        for (int j = 1; j <= 60; j++) begin
            @(negedge clk27);
            if (j == 2) vsync_cur = 1'b0;
            if (j == 6) vsync_cur = 1'b1;
`ifdef OUTSEQ_TXRST_EN
            if (tx_rst_n === 1'b0) begin
`else
            if (sel_out === 1'b0 && blank === 1'b1) begin
`endif
                found = 1;
                break;
            end
        end
        vectors++;
        if (found !== 1) begin
            miscompares++;
            $display("[TB] FAIL rstmid_reach_phase: got %0d, expected 1", found);
        end
        #2 reset_n = 1'b0;
        sel_req = 1'b1;
        #1;
        vectors++;
        if (sel_out !== 1'b1 || blank !== 1'b1 || tx_rst_n !== TX_RST_VAL || busy !== 1'b1
            || timeout !== 1'b0 || sw_count !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL rstmid_async_values: got sel=%b blank=%b tx=%b busy=%b to=%b cnt=%0d, expected 1 1 %b 1 0 0",
                     sel_out, blank, tx_rst_n, busy, timeout, sw_count, TX_RST_VAL);
        end
        repeat (2) @(negedge clk27);
        test_init_sequence("rstmid");
    endtask

    // Runs every scenario in order and prints the summary line
    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_switch_on_edge();
        test_timeout();
        test_abort();
        test_back_to_back();
        test_reset_mid_txrst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
